// File: rtl/lap_timer.sv
// lap_timer: HH:MM:SS stopwatch / countdown with an internal 1 s prescaler,
// synchronous load and clear, lap capture and countdown-expiry flags.
module lap_timer #(
  parameter int TICK_DIV = 100000000,
  parameter int HR_MOD   = 24,
  parameter int HR_W     = 5
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            run,
  input  logic            sclr,
  input  logic            dir,
  input  logic            load,
  input  logic [5:0]      ld_sec,
  input  logic [5:0]      ld_min,
  input  logic [HR_W-1:0] ld_hr,
  input  logic            lap,
  output logic [5:0]      sec,
  output logic [5:0]      min,
  output logic [HR_W-1:0] hr,
  output logic [5:0]      lap_sec,
  output logic [5:0]      lap_min,
  output logic [HR_W-1:0] lap_hr,
  output logic            lap_valid,
  output logic            sec_tick,
  output logic            expire,
  output logic            done
);

  localparam int            PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [HR_W-1:0]  HR_MAX  = HR_W'(HR_MOD - 1);

  logic [PRE_W-1:0] r_pre;
  logic [5:0]       r_sec;
  logic [5:0]       r_min;
  logic [HR_W-1:0]  r_hr;
  logic [5:0]       r_lap_sec;
  logic [5:0]       r_lap_min;
  logic [HR_W-1:0]  r_lap_hr;
  logic             r_lap_valid;
  logic             r_sec_tick;
  logic             r_expire;
  logic             r_done;

  logic             w_tick;
  logic             w_accept;
  logic             w_is_zero;
  logic             w_zero_hit;
  logic [5:0]       w_sec_nxt;
  logic [5:0]       w_min_nxt;
  logic [HR_W-1:0]  w_hr_nxt;
  logic [5:0]       w_ld_sec;
  logic [5:0]       w_ld_min;
  logic [HR_W-1:0]  w_ld_hr;

  // A tick fires on the last prescaler count of a running cycle; it only
  // moves the counters when neither clear nor load takes the edge.
  assign w_tick    = run && (r_pre == PRE_MAX);
  assign w_accept  = w_tick && !sclr && !load;
  assign w_is_zero = (r_sec == 6'd0) && (r_min == 6'd0) && (r_hr == '0);

  // Out-of-range load values clamp to the largest legal field value.
  assign w_ld_sec = (ld_sec > 6'd59) ? 6'd59 : ld_sec;
  assign w_ld_min = (ld_min > 6'd59) ? 6'd59 : ld_min;
  assign w_ld_hr  = (ld_hr > HR_MAX) ? HR_MAX : ld_hr;

  // Next count value for one tick in the current direction.
  always_comb begin
    w_sec_nxt  = r_sec;
    w_min_nxt  = r_min;
    w_hr_nxt   = r_hr;
    w_zero_hit = 1'b0;
    if (!dir) begin
      if (r_sec == 6'd59) begin
        w_sec_nxt = 6'd0;
        if (r_min == 6'd59) begin
          w_min_nxt = 6'd0;
          w_hr_nxt  = (r_hr == HR_MAX) ? '0 : r_hr + 1'b1;
        end else begin
          w_min_nxt = r_min + 6'd1;
        end
      end else begin
        w_sec_nxt = r_sec + 6'd1;
      end
    end else if (!w_is_zero) begin
      // A non-zero count with hr==0 and min==0 can only borrow within seconds,
      // so reaching 00:00:00 is exactly the case sec==1.
      w_zero_hit = (r_hr == '0) && (r_min == 6'd0) && (r_sec == 6'd1);
      if (r_sec != 6'd0) begin
        w_sec_nxt = r_sec - 6'd1;
      end else begin
        w_sec_nxt = 6'd59;
        if (r_min != 6'd0) begin
          w_min_nxt = r_min - 6'd1;
        end else begin
          w_min_nxt = 6'd59;
          w_hr_nxt  = r_hr - 1'b1;
        end
      end
    end
  end

  // Prescaler: holds while paused, restarts on clear or load.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pre <= '0;
    end else if (sclr || load) begin
      r_pre <= '0;
    end else if (run) begin
      r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
    end
  end

  // Time counters: clear beats load beats tick.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sec <= '0;
      r_min <= '0;
      r_hr  <= '0;
    end else if (sclr) begin
      r_sec <= '0;
      r_min <= '0;
      r_hr  <= '0;
    end else if (load) begin
      r_sec <= w_ld_sec;
      r_min <= w_ld_min;
      r_hr  <= w_ld_hr;
    end else if (w_tick) begin
      r_sec <= w_sec_nxt;
      r_min <= w_min_nxt;
      r_hr  <= w_hr_nxt;
    end
  end

  // Status flags: tick/expire pulses and the sticky countdown-done flag.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sec_tick <= 1'b0;
      r_expire   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_sec_tick <= w_accept;
      r_expire   <= w_accept && w_zero_hit;
      if (sclr || load) begin
        r_done <= 1'b0;
      end else if (w_accept && w_zero_hit) begin
        r_done <= 1'b1;
      end
    end
  end

  // Lap capture samples the pre-edge time; a coincident lap keeps the
  // capture valid even when the same edge clears the counters.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_lap_sec   <= '0;
      r_lap_min   <= '0;
      r_lap_hr    <= '0;
      r_lap_valid <= 1'b0;
    end else begin
      if (lap) begin
        r_lap_sec   <= r_sec;
        r_lap_min   <= r_min;
        r_lap_hr    <= r_hr;
        r_lap_valid <= 1'b1;
      end else if (sclr) begin
        r_lap_valid <= 1'b0;
      end
    end
  end

  assign sec       = r_sec;
  assign min       = r_min;
  assign hr        = r_hr;
  assign lap_sec   = r_lap_sec;
  assign lap_min   = r_lap_min;
  assign lap_hr    = r_lap_hr;
  assign lap_valid = r_lap_valid;
  assign sec_tick  = r_sec_tick;
  assign expire    = r_expire;
  assign done      = r_done;

endmodule
